// File: rtl/note_sequencer.sv
// Note sequencer: walks an external note table and drives hp/active of the square-wave synth.
// Optional macro NOTE_GAP_EN adds GAP_TICKS silent ticks at the end of every note.
module note_sequencer #(
   parameter int unsigned TICK_DIV  = 1000,
   parameter int unsigned SONG_LEN  = 32,
   parameter int unsigned GAP_TICKS = 1
) (
   input  logic        synth_clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        stop,
   input  logic        loop,
   input  logic [10:0] note_data,
   output logic [7:0]  note_idx,
   output logic [6:0]  hp,
   output logic        active,
   output logic        busy,
   output logic        done
);

   localparam int unsigned TW = $clog2(TICK_DIV);
   localparam int unsigned IW = 8;
   localparam int unsigned DW = 4;

   // Parameter sanity checks evaluated at elaboration.
   if (TICK_DIV < 2) begin : g_bad_tick_div
      $error("note_sequencer: TICK_DIV must be >= 2");
   end
   if (SONG_LEN < 1 || SONG_LEN > 256) begin : g_bad_song_len
      $error("note_sequencer: SONG_LEN must be in 1..256");
   end
   if (GAP_TICKS < 1) begin : g_bad_gap_ticks
      $error("note_sequencer: GAP_TICKS must be >= 1");
   end

`ifdef NOTE_GAP_EN
   localparam int unsigned GW = $clog2(GAP_TICKS + 1);
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY} state_t;
`endif

   state_t          state_q, state_d;
   logic [TW-1:0]   tick_q, tick_d;
   logic [DW-1:0]   dur_q, dur_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [6:0]      hp_q, hp_d;
   logic            active_q, active_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
`ifdef NOTE_GAP_EN
   logic [GW-1:0]   gap_q, gap_d;
`endif

   logic            tick_c;
   logic            adv_c;
   logic            end_c;

   assign tick_c = (tick_q == TW'(TICK_DIV - 1));

   // Next-state and next-output logic; stop overrides everything else.
   always_comb begin
      state_d  = state_q;
      tick_d   = tick_q;
      dur_d    = dur_q;
      idx_d    = idx_q;
      hp_d     = hp_q;
      active_d = active_q;
      done_d   = 1'b0;
`ifdef NOTE_GAP_EN
      gap_d    = gap_q;
`endif
      adv_c    = 1'b0;
      end_c    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LOAD;
               idx_d   = '0;
            end
         end
         S_LOAD: begin
            if (note_data[3:0] == 4'd0) begin
               end_c = 1'b1;
            end else begin
               hp_d     = note_data[10:4];
               active_d = (note_data[10:4] != 7'd0);
               dur_d    = note_data[3:0];
               tick_d   = '0;
               state_d  = S_PLAY;
            end
         end
         S_PLAY: begin
            tick_d = tick_c ? '0 : tick_q + TW'(1);
            if (tick_c) begin
               dur_d = dur_q - DW'(1);
               if (dur_q == DW'(1)) begin
`ifdef NOTE_GAP_EN
                  state_d  = S_GAP;
                  active_d = 1'b0;
                  gap_d    = GW'(GAP_TICKS);
`else
                  adv_c    = 1'b1;
`endif
               end
            end
         end
`ifdef NOTE_GAP_EN
         S_GAP: begin
            tick_d = tick_c ? '0 : tick_q + TW'(1);
            if (tick_c) begin
               gap_d = gap_q - GW'(1);
               if (gap_q == GW'(1)) begin
                  adv_c = 1'b1;
               end
            end
         end
`endif
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Advance to the next entry, or treat the table end as end-of-song.
      if (adv_c) begin
         if (idx_q == IW'(SONG_LEN - 1)) begin
            end_c = 1'b1;
         end else begin
            idx_d   = idx_q + IW'(1);
            state_d = S_LOAD;
         end
      end

      if (end_c) begin
         idx_d = '0;
         if (loop) begin
            state_d = S_LOAD;
         end else begin
            state_d  = S_IDLE;
            done_d   = 1'b1;
            hp_d     = '0;
            active_d = 1'b0;
         end
      end

      if (stop) begin
         state_d  = S_IDLE;
         tick_d   = '0;
         dur_d    = '0;
         idx_d    = '0;
         hp_d     = '0;
         active_d = 1'b0;
         done_d   = 1'b0;
`ifdef NOTE_GAP_EN
         gap_d    = '0;
`endif
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge synth_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         tick_q   <= '0;
         dur_q    <= '0;
         idx_q    <= '0;
         hp_q     <= '0;
         active_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef NOTE_GAP_EN
         gap_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         tick_q   <= tick_d;
         dur_q    <= dur_d;
         idx_q    <= idx_d;
         hp_q     <= hp_d;
         active_q <= active_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef NOTE_GAP_EN
         gap_q    <= gap_d;
`endif
      end
   end

   assign note_idx = idx_q;
   assign hp       = hp_q;
   assign active   = active_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with TICK_DIV=4, SONG_LEN=4, GAP_TICKS=1.
// Build with NOTE_GAP_EN defined to exercise the gap variant.
module tb_note_sequencer;

   localparam int unsigned TICK_DIV  = 4;
   localparam int unsigned SONG_LEN  = 4;
   localparam int unsigned GAP_TICKS = 1;
`ifdef NOTE_GAP_EN
   localparam int GAPC = 4;
`else
   localparam int GAPC = 0;
`endif

   logic        synth_clk = 1'b0;
   logic        rst_n     = 1'b0;
   logic        start     = 1'b0;
   logic        stop      = 1'b0;
   logic        loop      = 1'b0;
   logic [10:0] note_data;
   logic [7:0]  note_idx;
   logic [6:0]  hp;
   logic        active;
   logic        busy;
   logic        done;

   logic [10:0] rom [256];
   int          total  = 0;
   int          passed = 0;

   assign note_data = rom[note_idx];

   always #5 synth_clk = ~synth_clk;

   note_sequencer #(
      .TICK_DIV (TICK_DIV),
      .SONG_LEN (SONG_LEN),
      .GAP_TICKS(GAP_TICKS)
   ) dut (
      .synth_clk(synth_clk),
      .rst_n    (rst_n),
      .start    (start),
      .stop     (stop),
      .loop     (loop),
      .note_data(note_data),
      .note_idx (note_idx),
      .hp       (hp),
      .active   (active),
      .busy     (busy),
      .done     (done)
   );

   function automatic logic [10:0] ent(input logic [6:0] h, input logic [3:0] d);
      return {h, d};
   endfunction

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = 11'd0;
   endtask

   task automatic step();
      @(posedge synth_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic chk_all(input string tag, input logic [6:0] e_hp, input logic e_act,
                          input logic [7:0] e_idx, input logic e_busy, input logic e_done);
      check({tag, ".hp"},     8'(hp),     8'(e_hp));
      check({tag, ".active"}, 8'(active), 8'(e_act));
      check({tag, ".idx"},    note_idx,   e_idx);
      check({tag, ".busy"},   8'(busy),   8'(e_busy));
      check({tag, ".done"},   8'(done),   8'(e_done));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_rom();
      repeat (2) step();
      chk_all("rst_hold", 7'd0, 1'b0, 8'd0, 1'b0, 1'b0);
      rst_n = 1'b1;
      step();
      chk_all("idle", 7'd0, 1'b0, 8'd0, 1'b0, 1'b0);

`ifndef NOTE_GAP_EN
      // Basic sequence: note, rest, note, end marker.
      rom[0] = ent(7'd10, 4'd2);
      rom[1] = ent(7'd0,  4'd1);
      rom[2] = ent(7'd20, 4'd1);
      rom[3] = ent(7'd0,  4'd0);
      start = 1'b1;
      step();
      start = 1'b0;
      chk_all("b_load0", 7'd0, 1'b0, 8'd0, 1'b1, 1'b0);
      repeat (8) begin step(); chk_all("b_note0", 7'd10, 1'b1, 8'd0, 1'b1, 1'b0); end
      step(); chk_all("b_load1", 7'd10, 1'b1, 8'd1, 1'b1, 1'b0);
      repeat (4) begin step(); chk_all("b_rest", 7'd0, 1'b0, 8'd1, 1'b1, 1'b0); end
      step(); chk_all("b_load2", 7'd0, 1'b0, 8'd2, 1'b1, 1'b0);
      repeat (4) begin step(); chk_all("b_note2", 7'd20, 1'b1, 8'd2, 1'b1, 1'b0); end
      step(); chk_all("b_load3", 7'd20, 1'b1, 8'd3, 1'b1, 1'b0);
      step(); chk_all("b_done", 7'd0, 1'b0, 8'd0, 1'b0, 1'b1);
      step(); chk_all("b_after", 7'd0, 1'b0, 8'd0, 1'b0, 1'b0);
`else
      // Gap variant: two identical notes separated by silent ticks.
      rom[0] = ent(7'd10, 4'd2);
      rom[1] = ent(7'd10, 4'd2);
      rom[2] = ent(7'd0,  4'd0);
      start = 1'b1;
      step();
      start = 1'b0;
      chk_all("g_load0", 7'd0, 1'b0, 8'd0, 1'b1, 1'b0);
      repeat (8) begin step(); chk_all("g_note0", 7'd10, 1'b1, 8'd0, 1'b1, 1'b0); end
      repeat (4) begin step(); chk_all("g_gap0", 7'd10, 1'b0, 8'd0, 1'b1, 1'b0); end
      step(); chk_all("g_load1", 7'd10, 1'b0, 8'd1, 1'b1, 1'b0);
      repeat (8) begin step(); chk_all("g_note1", 7'd10, 1'b1, 8'd1, 1'b1, 1'b0); end
      repeat (4) begin step(); chk_all("g_gap1", 7'd10, 1'b0, 8'd1, 1'b1, 1'b0); end
      step(); chk_all("g_load2", 7'd10, 1'b0, 8'd2, 1'b1, 1'b0);
      step(); chk_all("g_done", 7'd0, 1'b0, 8'd0, 1'b0, 1'b1);
      step(); chk_all("g_after", 7'd0, 1'b0, 8'd0, 1'b0, 1'b0);
`endif

      // Loop: four d=1 entries without end marker, start pulsed while busy.
      clear_rom();
      for (int k = 0; k < 4; k++) rom[k] = ent(7'(5 + k), 4'd1);
      loop  = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         for (int j = 0; j < 5 + GAPC; j++) begin
            check("loop.idx", note_idx, 8'(k % 4));
            check("loop.busy", 8'(busy), 8'd1);
            check("loop.done", 8'(done), 8'd0);
            if (j >= 1 && j <= 4) begin
               check("loop.hp", 8'(hp), 8'(5 + k % 4));
               check("loop.active", 8'(active), 8'd1);
            end else if (j > 4) begin
               check("loop.gap_active", 8'(active), 8'd0);
            end
            start = (k == 1 && j == 2);
            step();
         end
      end
      start = 1'b0;
      check("loop.wrap_idx", note_idx, 8'd0);
      step();
      check("loop.replay_hp", 8'(hp), 8'd5);

      // Asynchronous reset in the middle of a note.
      #2;
      rst_n = 1'b0;
      #1;
      chk_all("rst_async", 7'd0, 1'b0, 8'd0, 1'b0, 1'b0);
      step();
      chk_all("rst_held", 7'd0, 1'b0, 8'd0, 1'b0, 1'b0);
      rst_n = 1'b1;
      loop  = 1'b0;
      step();

      // Stop during entry 1 together with a start.
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (5 + GAPC) step();
      step();
      chk_all("s_entry1", 7'd6, 1'b1, 8'd1, 1'b1, 1'b0);
      stop  = 1'b1;
      start = 1'b1;
      step();
      stop  = 1'b0;
      start = 1'b0;
      chk_all("s_stop", 7'd0, 1'b0, 8'd0, 1'b0, 1'b0);
      repeat (3) begin step(); chk_all("s_idle", 7'd0, 1'b0, 8'd0, 1'b0, 1'b0); end

      // Immediate end marker at entry 0, start held while busy.
      clear_rom();
      start = 1'b1;
      step();
      chk_all("e_load", 7'd0, 1'b0, 8'd0, 1'b1, 1'b0);
      step();
      start = 1'b0;
      chk_all("e_done", 7'd0, 1'b0, 8'd0, 1'b0, 1'b1);
      step();
      chk_all("e_after", 7'd0, 1'b0, 8'd0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Note sequencer that walks an external note table and drives the half-period (`hp`) and `active` inputs of the square-wave synth stage directly downstream. It runs on the synth clock and times note durations with an internal tempo prescaler. It supports start, stop and loop control, and reports progress through `busy`, `note_idx` and a one-cycle `done` pulse.

## Interface
- `TICK_DIV`, default 1000: `synth_clk` cycles per tempo tick; ≥2.
- `SONG_LEN`, default 32: table entries, 1..256.
- `GAP_TICKS`, default 1: silent ticks at each note end; used only with `NOTE_GAP_EN`; ≥1.

Ports:
- `synth_clk`  in  1  clock, shared with the synth stage.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level-sampled; begins playback from entry 0 when idle.
- `stop`  in  1  aborts playback; highest priority.
- `loop`  in  1  sampled at song end; 1 restarts at entry 0.
- `note_data`  in  11  table word for `note_idx`, read combinationally.
  - `[10:4]` = half-period; 0 = rest.
  - `[3:0]` = duration in ticks; 0 = end-of-song marker.
- `note_idx`  out  8  current table address, registered.
- `hp`  out  7  half-period to the synth, registered.
- `active`  out  1  synth enable, registered.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse at a natural song end.

## Operation
States: IDLE, LOAD, PLAY, GAP (GAP exists only with the macro).

- **Reset:** state is IDLE; all outputs are 0 (`hp`, `active`, `note_idx`, `busy`, `done`); tick counter, duration counter and gap counter are 0.
- **IDLE:** `start`=1 → LOAD with `note_idx`=0. `hp`/`active` stay 0.
- **LOAD:** lasts one cycle and samples `note_data`.
  - Duration 0 (end marker) → END.
  - Otherwise:
    - `hp`←`[10:4]`; `active`←(`[10:4]`≠0).
    - `dur_ctr`←`[3:0]`; tick counter cleared.
    - Next state PLAY.
- **PLAY:** the tick counter counts 0..`TICK_DIV`-1; a tick fires on wrap. Each tick decrements `dur_ctr`. A tick with `dur_ctr`=1 ends the note:
  - With gap: → GAP.
  - Without gap: → ADVANCE.
- **GAP:** `active`←0 and `hp` is held. After `GAP_TICKS` ticks → ADVANCE.
- **ADVANCE** is not a separate state; it is resolved on the same edge.
  - If `note_idx`=`SONG_LEN`-1 → END.
  - Else `note_idx`+1 → LOAD.
- **END** is not a separate state; it is resolved on the same edge.
  - `loop`=1 → `note_idx`←0, LOAD, no `done`.
  - `loop`=0 → IDLE, `done`=1 for one cycle, `hp`←0, `active`←0.
- **`stop`** in any state → IDLE on the next edge: `hp`=0, `active`=0, `note_idx`=0, no `done`. `stop` wins over a simultaneous `start`.
- **`start` while busy:** ignored.
- **Rest entries** (`hp`=0) time like notes, with `active`=0.
- **Asynchronous reset mid-song:** every output is 0 immediately, whatever the state.

## Timing
- `start` sampled at edge N: LOAD occupies cycle N+1. `hp`/`active` are valid from edge N+2.
- Note of duration D: `hp`/`active` are stable for D·`TICK_DIV` cycles.
  - Without gap: the next LOAD follows immediately, so each entry takes 1 + D·`TICK_DIV` cycles.
  - With gap: `active`=0 for the final `GAP_TICKS`·`TICK_DIV` cycles. These gap cycles add to the note length, they do not shorten it.
- `note_idx` changes on the edge that enters LOAD. `note_data` must settle within that cycle.
- `done` asserts in the cycle after the end-of-song decision; `busy` falls in that same cycle.
- Counter widths:
  - Tick counter: `$clog2(TICK_DIV)` bits.
  - Duration counter: 4 bits.
  - Gap counter: ≥`$clog2(GAP_TICKS+1)` bits.
  - No counter may overflow.

## Configuration
- `NOTE_GAP_EN` defined: GAP state and gap counter are compiled in. Each note ends with `GAP_TICKS` silent ticks so repeated identical notes are audibly separated.
- Undefined: no GAP state. Notes run back-to-back and `active` stays high across consecutive non-rest notes. `GAP_TICKS` is unused.

## Test plan
All scenarios use `TICK_DIV`=4, `SONG_LEN`=4, `GAP_TICKS`=1.
- **Reset:** assert `rst_n`=0 mid-PLAY → `hp`=0, `active`=0, `busy`=0, `note_idx`=0 asynchronously.
- **Basic sequence:** table {hp=10,d=2},{hp=0,d=1},{hp=20,d=1},{d=0}, `loop`=0, macro off.
  - Expect `hp`=10/`active`=1 for 8 cycles.
  - Then a LOAD cycle, a rest of 4 cycles, `hp`=20 for 4 cycles.
  - Then `done` pulses once and `busy`=0.
- **Loop:** 4 entries with d=1, no end marker, `loop`=1 → `note_idx` wraps 3→0, `done` never pulses, `busy` stays 1.
- **Stop mid-note:** `stop` during entry 1 → next cycle IDLE, `active`=0, `note_idx`=0, no `done`. A `start` asserted together with `stop` is ignored.
- **Gap:** `NOTE_GAP_EN` with {hp=10,d=2},{hp=10,d=2},{d=0} → each note has `active`=1 for 8 cycles then 0 for 4 cycles.
- **Start while busy:** a `start` pulse while busy does not change `note_idx`. An immediate end marker at entry 0 yields `done` 2 cycles after `start` with `active` never high.
